// File: rtl/video_timing_gen_pkg.sv
// Shared types for the Pocket video path: the rgb_t pixel format,
// the video_timing_t bundle of raster timing values and the default
// 740x500 raster. Also holds the colour-bar lookup used when the
// VIDEO_TIMING_GEN_PATTERN_EN build option is enabled.
package pocket;

  // Raster counters cover totals up to 1024, so 10 bits are enough.
  localparam int CNT_W = 10;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef struct packed {
    int h_total;
    int v_total;
    int hs_pos;
    int vs_line;
    int h_act_start;
    int h_active;
    int v_act_start;
    int v_active;
  } video_timing_t;

  localparam video_timing_t VIDEO_TIMING_DEFAULT = '{
    h_total:     740,
    v_total:     500,
    hs_pos:      50,
    vs_line:     50,
    h_act_start: 100,
    h_active:    400,
    v_act_start: 100,
    v_active:    360
  };

  // Eight vertical bars: bit0 drives blue, bit1 red, bit2 green.
  function automatic rgb_t colour_bar(input logic [2:0] idx);
    rgb_t c;
    c.r = {8{idx[1]}};
    c.g = {8{idx[2]}};
    c.b = {8{idx[0]}};
    return c;
  endfunction

endpackage

// File: rtl/video_timing_gen_raster_counter.sv
// Free-running horizontal/vertical raster counters. hcount advances every
// clock and wraps at H_TOTAL-1; vcount advances on each line wrap and
// wraps at V_TOTAL-1. line_end/frame_end flag the last clock of a line
// and of a frame so the parent can anticipate the wrap.
module video_raster_counter
  import pocket::*;
#(
  parameter int H_TOTAL = 740,
  parameter int V_TOTAL = 500
) (
  input  logic             rgb_clock,
  input  logic             reset_n,
  output logic [CNT_W-1:0] hcount,
  output logic [CNT_W-1:0] vcount,
  output logic             line_end,
  output logic             frame_end
);

  logic [CNT_W-1:0] r_hcount;
  logic [CNT_W-1:0] r_vcount;
  logic             w_line_end;
  logic             w_frame_end;

  assign w_line_end  = (r_hcount == CNT_W'(H_TOTAL - 1));
  assign w_frame_end = w_line_end && (r_vcount == CNT_W'(V_TOTAL - 1));

  // Advance the raster one pixel per clock, wrapping line and frame.
  always_ff @(posedge rgb_clock) begin
    if (!reset_n) begin
      r_hcount <= '0;
      r_vcount <= '0;
    end else if (w_line_end) begin
      r_hcount <= '0;
      r_vcount <= w_frame_end ? '0 : r_vcount + 1'b1;
    end else begin
      r_hcount <= r_hcount + 1'b1;
    end
  end

  assign hcount    = r_hcount;
  assign vcount    = r_vcount;
  assign line_end  = w_line_end;
  assign frame_end = w_frame_end;

endmodule

// File: rtl/video_timing_gen.sv
// Pocket video source stage. Generates sync/data-enable from free-running
// raster counters and pulls active pixels from an upstream valid/ready
// stream. Every output is registered together, one clock behind the
// counter state. A starved stream substitutes UNDERFLOW_RGB and sets a
// sticky underflow flag; timing never stalls.
// Outputs map one-to-one onto the video_if fields (rgb, de, hs, vs, skip)
// and are bundled onto the interface by the parent.
// Build option VIDEO_TIMING_GEN_PATTERN_EN adds a pattern_sel input that
// replaces the stream with eight colour bars, switched on frame boundaries.
module video_timing_gen
  import pocket::*;
#(
  parameter int          H_TOTAL       = VIDEO_TIMING_DEFAULT.h_total,
  parameter int          V_TOTAL       = VIDEO_TIMING_DEFAULT.v_total,
  parameter int          HS_POS        = VIDEO_TIMING_DEFAULT.hs_pos,
  parameter int          VS_LINE       = VIDEO_TIMING_DEFAULT.vs_line,
  parameter int          H_ACT_START   = VIDEO_TIMING_DEFAULT.h_act_start,
  parameter int          H_ACTIVE      = VIDEO_TIMING_DEFAULT.h_active,
  parameter int          V_ACT_START   = VIDEO_TIMING_DEFAULT.v_act_start,
  parameter int          V_ACTIVE      = VIDEO_TIMING_DEFAULT.v_active,
  parameter logic [23:0] UNDERFLOW_RGB = 24'hFF00FF
) (
  input  logic             rgb_clock,
  input  logic             reset_n,
  input  rgb_t             pix_data,
  input  logic             pix_valid,
  output logic             pix_ready,
  output rgb_t             video_rgb,
  output logic             video_de,
  output logic             video_hs,
  output logic             video_vs,
  output logic             video_skip,
  output logic [CNT_W-1:0] pos_x,
  output logic [CNT_W-1:0] pos_y,
  output logic             frame_start,
  output logic             underflow,
  input  logic             underflow_clr
`ifdef VIDEO_TIMING_GEN_PATTERN_EN
  ,
  input  logic             pattern_sel
`endif
);

  // Catch impossible raster geometry at elaboration time.
  if (H_TOTAL < 2 || H_TOTAL > 1024) begin : g_bad_h_total
    $error("video_timing_gen: H_TOTAL must be in 2..1024");
  end
  if (V_TOTAL < 2 || V_TOTAL > 1024) begin : g_bad_v_total
    $error("video_timing_gen: V_TOTAL must be in 2..1024");
  end
  if (H_ACT_START + H_ACTIVE > H_TOTAL) begin : g_bad_h_active
    $error("video_timing_gen: H_ACT_START+H_ACTIVE exceeds H_TOTAL");
  end
  if (V_ACT_START + V_ACTIVE > V_TOTAL) begin : g_bad_v_active
    $error("video_timing_gen: V_ACT_START+V_ACTIVE exceeds V_TOTAL");
  end
  if (HS_POS >= H_TOTAL) begin : g_bad_hs_pos
    $error("video_timing_gen: HS_POS must be below H_TOTAL");
  end
  if (VS_LINE >= V_TOTAL) begin : g_bad_vs_line
    $error("video_timing_gen: VS_LINE must be below V_TOTAL");
  end

  // Active window bounds, one bit wider than the counters so the exclusive
  // upper bound (up to 1024) still fits.
  localparam logic [CNT_W:0] LP_H_LO = (CNT_W + 1)'(H_ACT_START);
  localparam logic [CNT_W:0] LP_H_HI = (CNT_W + 1)'(H_ACT_START + H_ACTIVE);
  localparam logic [CNT_W:0] LP_V_LO = (CNT_W + 1)'(V_ACT_START);
  localparam logic [CNT_W:0] LP_V_HI = (CNT_W + 1)'(V_ACT_START + V_ACTIVE);

  logic [CNT_W-1:0] w_hcount;
  logic [CNT_W-1:0] w_vcount;
  logic             w_line_end;
  logic             w_frame_end;

  logic             r_line_start;
  logic             r_frame_origin;

  logic             w_h_act;
  logic             w_v_act;
  logic             w_de;
  logic             w_hs;
  logic             w_vs;
  logic             w_fs;
  logic             w_pattern;
  logic             w_starve;
  logic [CNT_W-1:0] w_pos_x;
  logic [CNT_W-1:0] w_pos_y;
  rgb_t             w_rgb;

  rgb_t             r_rgb;
  logic             r_de;
  logic             r_hs;
  logic             r_vs;
  logic             r_fs;
  logic [CNT_W-1:0] r_pos_x;
  logic [CNT_W-1:0] r_pos_y;
  logic             r_underflow;

  video_raster_counter #(
    .H_TOTAL (H_TOTAL),
    .V_TOTAL (V_TOTAL)
  ) u_raster (
    .rgb_clock (rgb_clock),
    .reset_n   (reset_n),
    .hcount    (w_hcount),
    .vcount    (w_vcount),
    .line_end  (w_line_end),
    .frame_end (w_frame_end)
  );

  // Registered "counter is at hcount 0" / "counter is at (0,0)" flags, so
  // the line and frame origin decodes are single flops rather than
  // wide compares. Reset puts the counters at the origin, hence set to 1.
  always_ff @(posedge rgb_clock) begin
    if (!reset_n) begin
      r_line_start   <= 1'b1;
      r_frame_origin <= 1'b1;
    end else begin
      r_line_start   <= w_line_end;
      r_frame_origin <= w_frame_end;
    end
  end

`ifdef VIDEO_TIMING_GEN_PATTERN_EN
  logic r_pattern;

  // Latch the pattern request only at the frame origin so the source never
  // changes mid-frame.
  always_ff @(posedge rgb_clock) begin
    if (!reset_n) begin
      r_pattern <= 1'b0;
    end else if (w_fs) begin
      r_pattern <= pattern_sel;
    end
  end

  assign w_pattern = r_pattern;
`else
  assign w_pattern = 1'b0;
`endif

  // Decodes are gated by reset_n so no pixel is accepted while reset is
  // held, even for a raster whose active window starts at (0,0).
  assign w_h_act  = ({1'b0, w_hcount} >= LP_H_LO) && ({1'b0, w_hcount} < LP_H_HI);
  assign w_v_act  = ({1'b0, w_vcount} >= LP_V_LO) && ({1'b0, w_vcount} < LP_V_HI);
  assign w_de     = reset_n && w_h_act && w_v_act;
  assign w_hs     = (w_hcount == CNT_W'(HS_POS));
  assign w_vs     = r_line_start && (w_vcount == CNT_W'(VS_LINE));
  assign w_fs     = r_frame_origin;
  assign w_starve = w_de && !pix_valid && !w_pattern;
  assign w_pos_x  = w_de ? (w_hcount - CNT_W'(H_ACT_START)) : '0;
  assign w_pos_y  = w_de ? (w_vcount - CNT_W'(V_ACT_START)) : '0;

  assign pix_ready = w_de && !w_pattern;

  // Select the pixel colour for this raster position.
  always_comb begin
    w_rgb = '0;
    if (w_de) begin
      if (w_pattern) begin
        w_rgb = colour_bar(w_pos_x[8:6]);
      end else if (pix_valid) begin
        w_rgb = pix_data;
      end else begin
        w_rgb = rgb_t'(UNDERFLOW_RGB);
      end
    end
  end

  // Register every video output together so they stay mutually aligned.
  always_ff @(posedge rgb_clock) begin
    if (!reset_n) begin
      r_rgb   <= '0;
      r_de    <= 1'b0;
      r_hs    <= 1'b0;
      r_vs    <= 1'b0;
      r_fs    <= 1'b0;
      r_pos_x <= '0;
      r_pos_y <= '0;
    end else begin
      r_rgb   <= w_rgb;
      r_de    <= w_de;
      r_hs    <= w_hs;
      r_vs    <= w_vs;
      r_fs    <= w_fs;
      r_pos_x <= w_pos_x;
      r_pos_y <= w_pos_y;
    end
  end

  // Sticky starvation flag; a new starvation beats a simultaneous clear.
  always_ff @(posedge rgb_clock) begin
    if (!reset_n) begin
      r_underflow <= 1'b0;
    end else if (w_starve) begin
      r_underflow <= 1'b1;
    end else if (underflow_clr) begin
      r_underflow <= 1'b0;
    end
  end

  assign video_rgb   = r_rgb;
  assign video_de    = r_de;
  assign video_hs    = r_hs;
  assign video_vs    = r_vs;
  assign video_skip  = 1'b0;
  assign pos_x       = r_pos_x;
  assign pos_y       = r_pos_y;
  assign frame_start = r_fs;
  assign underflow   = r_underflow;

endmodule

// File: tb/tb_video_timing_gen.sv
// Self-checking bench for video_timing_gen on a shrunken 20x12 raster so
// whole frames fit in a short run. A reference model of the raster pushes
// the expected output record into a queue on every driven cycle; the record
// is popped and compared once the DUT has registered its outputs.
module tb_video_timing_gen;
  import pocket::*;

  localparam int H_TOTAL     = 20;
  localparam int V_TOTAL     = 12;
  localparam int HS_POS      = 3;
  localparam int VS_LINE     = 2;
  localparam int H_ACT_START = 5;
  localparam int H_ACTIVE    = 8;
  localparam int V_ACT_START = 3;
  localparam int V_ACTIVE    = 6;
  localparam int FRAME       = H_TOTAL * V_TOTAL;
  localparam logic [23:0] UNDER = 24'hFF00FF;

  logic       rgb_clock = 1'b0;
  logic       reset_n = 1'b0;
  rgb_t       pix_data = '0;
  logic       pix_valid = 1'b0;
  logic       pix_ready;
  rgb_t       video_rgb;
  logic       video_de, video_hs, video_vs, video_skip;
  logic [9:0] pos_x, pos_y;
  logic       frame_start;
  logic       underflow;
  logic       underflow_clr = 1'b0;
`ifdef VIDEO_TIMING_GEN_PATTERN_EN
  logic       patternSel = 1'b0;
`endif

  video_timing_gen #(
    .H_TOTAL       (H_TOTAL),
    .V_TOTAL       (V_TOTAL),
    .HS_POS        (HS_POS),
    .VS_LINE       (VS_LINE),
    .H_ACT_START   (H_ACT_START),
    .H_ACTIVE      (H_ACTIVE),
    .V_ACT_START   (V_ACT_START),
    .V_ACTIVE      (V_ACTIVE),
    .UNDERFLOW_RGB (UNDER)
  ) dut (
    .rgb_clock     (rgb_clock),
    .reset_n       (reset_n),
    .pix_data      (pix_data),
    .pix_valid     (pix_valid),
    .pix_ready     (pix_ready),
    .video_rgb     (video_rgb),
    .video_de      (video_de),
    .video_hs      (video_hs),
    .video_vs      (video_vs),
    .video_skip    (video_skip),
    .pos_x         (pos_x),
    .pos_y         (pos_y),
    .frame_start   (frame_start),
    .underflow     (underflow),
    .underflow_clr (underflow_clr)
`ifdef VIDEO_TIMING_GEN_PATTERN_EN
    ,
    .pattern_sel   (patternSel)
`endif
  );

  // Free-running pixel clock.
  always #5 rgb_clock = ~rgb_clock;

  typedef struct packed {
    logic [23:0] rgb;
    logic        de;
    logic        hs;
    logic        vs;
    logic        fs;
    logic        skip;
    logic [9:0]  px;
    logic [9:0]  py;
    logic        uf;
  } outRec_t;

  typedef struct {
    int   h;
    int   v;
    logic valid;
    logic clr;
    logic expUf;
  } ufVec_t;

  outRec_t     expQ[$];
  int          total = 0;
  int          bad = 0;
  int          mh = 0;
  int          mv = 0;
  logic        mUf = 1'b0;
  logic [23:0] dataReg = 24'h100000;
  int          consumedCount = 0;

  // Count one comparison and report it if the values differ.
  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic modelDe();
    return (mh >= H_ACT_START) && (mh < H_ACT_START + H_ACTIVE) &&
           (mv >= V_ACT_START) && (mv < V_ACT_START + V_ACTIVE);
  endfunction

  function automatic outRec_t sampleDut();
    outRec_t a;
    a.rgb  = video_rgb;
    a.de   = video_de;
    a.hs   = video_hs;
    a.vs   = video_vs;
    a.fs   = frame_start;
    a.skip = video_skip;
    a.px   = pos_x;
    a.py   = pos_y;
    a.uf   = underflow;
    return a;
  endfunction

  // Drive one clock of stimulus (called just after a falling edge), push the
  // model's expected outputs, then compare once the DUT registers them.
  task automatic applyStimulus(input logic valid, input logic clr, input logic rstn);
    outRec_t e;
    outRec_t a;
    logic    d;
    logic    consumed;
    pix_valid     = valid;
    underflow_clr = clr;
    reset_n       = rstn;
    pix_data      = rgb_t'(dataReg);
    d = rstn && modelDe();
    e = '0;
    if (!rstn) begin
      mUf = 1'b0;
    end else begin
      e.rgb = d ? (valid ? dataReg : UNDER) : 24'h0;
      e.de  = d;
      e.hs  = (mh == HS_POS);
      e.vs  = (mh == 0) && (mv == VS_LINE);
      e.fs  = (mh == 0) && (mv == 0);
      e.px  = d ? 10'(mh - H_ACT_START) : 10'd0;
      e.py  = d ? 10'(mv - V_ACT_START) : 10'd0;
      if (d && !valid) mUf = 1'b1;
      else if (clr)    mUf = 1'b0;
      e.uf  = mUf;
    end
    expQ.push_back(e);
    if (!rstn) begin
      mh = 0;
      mv = 0;
    end else if (mh == H_TOTAL - 1) begin
      mh = 0;
      mv = (mv == V_TOTAL - 1) ? 0 : mv + 1;
    end else begin
      mh++;
    end
    #1;
    checkOutput("pix_ready", pix_ready, d);
    consumed = pix_valid && pix_ready;
    @(posedge rgb_clock);
    #1;
    a = sampleDut();
    e = expQ.pop_front();
    checkOutput("outputs", a, e);
    if (consumed) begin
      dataReg++;
      consumedCount++;
    end
    @(negedge rgb_clock);
  endtask

  // Run plain streaming cycles until the model raster reaches (h, v).
  task automatic advanceTo(input int h, input int v);
    int n = 0;
    while (!(mh == h && mv == v) && n < 2 * FRAME) begin
      applyStimulus(1'b1, 1'b0, 1'b1);
      n++;
    end
  endtask

  // Hard stop in case something blocks the main sequence.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    ufVec_t tbl[6];
    int     fsIdx[$];
    int     lineDe[V_TOTAL];
    int     hsCnt = 0;
    int     vsCnt = 0;
    int     consumedFrame = 0;
    logic   sawFirst = 1'b0;
    logic [23:0] firstRgb = '0;
    logic [23:0] held;

    tbl[0] = '{7,  5, 1'b0, 1'b1, 1'b1};
    tbl[1] = '{15, 5, 1'b1, 1'b1, 1'b0};
    tbl[2] = '{16, 5, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{8,  6, 1'b0, 1'b0, 1'b1};
    tbl[4] = '{10, 6, 1'b1, 1'b1, 1'b0};
    tbl[5] = '{2,  7, 1'b0, 1'b0, 1'b0};
    for (int l = 0; l < V_TOTAL; l++) lineDe[l] = 0;

    $display("[TB] start");
    @(negedge rgb_clock);

    // Reset state.
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("reset_outputs", sampleDut(), '0);
    checkOutput("reset_ready", pix_ready, 1'b0);

    // Two frames of continuous streaming.
    for (int i = 0; i < 2 * FRAME; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b1);
      if (frame_start) fsIdx.push_back(i);
      if (video_de && !sawFirst) begin
        sawFirst = 1'b1;
        firstRgb = video_rgb;
      end
      if (i < FRAME) begin
        if (video_de) lineDe[i / H_TOTAL]++;
        if (video_hs) hsCnt++;
        if (video_vs) vsCnt++;
        if (i == FRAME - 1) consumedFrame = consumedCount;
      end
    end
    for (int l = 0; l < V_TOTAL; l++)
      checkOutput($sformatf("de_line%0d", l), lineDe[l],
                  (l >= V_ACT_START && l < V_ACT_START + V_ACTIVE) ? H_ACTIVE : 0);
    checkOutput("consumed_frame", consumedFrame, H_ACTIVE * V_ACTIVE);
    checkOutput("hs_per_frame", hsCnt, V_TOTAL);
    checkOutput("vs_per_frame", vsCnt, 1);
    checkOutput("first_rgb", firstRgb, 24'h100000);
    checkOutput("fs_count", fsIdx.size(), 2);
    checkOutput("fs_first", (fsIdx.size() > 0) ? fsIdx[0] : -1, 0);
    checkOutput("fs_period", (fsIdx.size() > 1) ? fsIdx[1] - fsIdx[0] : -1, FRAME);

    // Three starved cycles at active (x=2, y=1).
    advanceTo(H_ACT_START + 2, V_ACT_START + 1);
    held = dataReg;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("starve_rgb", video_rgb, UNDER);
      checkOutput("starve_uf", underflow, 1'b1);
    end
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("resume_rgb", video_rgb, held);
    applyStimulus(1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("uf_sticky", underflow, 1'b1);

    // Underflow set/clear table.
    for (int k = 0; k < 6; k++) begin
      advanceTo(tbl[k].h, tbl[k].v);
      applyStimulus(tbl[k].valid, tbl[k].clr, 1'b1);
      checkOutput($sformatf("uf_tbl%0d", k), underflow, tbl[k].expUf);
    end

    // One-cycle reset in the middle of an active line.
    advanceTo(10, 6);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("midrst_outputs", sampleDut(), '0);
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("midrst_fs", frame_start, 1'b1);
    checkOutput("midrst_hs", video_hs, 1'b0);
    checkOutput("midrst_vs", video_vs, 1'b0);
    hsCnt = 0;
    vsCnt = 0;
    for (int i = 1; i < FRAME; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b1);
      if (video_hs) hsCnt++;
      if (video_vs) vsCnt++;
    end
    checkOutput("midrst_hs_count", hsCnt, V_TOTAL);
    checkOutput("midrst_vs_count", vsCnt, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
